// File: rtl/handshake_reader.sv
// handshake_reader
// Consumer endpoint for the 4-phase ready/ack handshake on the read port of
// the cross-domain handshake FIFO. It captures each offered word once and
// acknowledges it on hs_ack. Captured words go into a small local queue,
// which is re-presented downstream as a valid/ready stream.
//
// Optional feature: define HS_READER_SYNC_IN_EN to pass hs_ready through a
// 2-flop synchroniser before the FSM sees it. This adds two cycles to capture
// latency and two cycles to ack-release latency. hs_data does not need
// synchronising, because the FIFO holds it stable until it observes hs_ack.
// When the macro is undefined, hs_ready is assumed to be already synchronous
// to clk and is used directly.

module handshake_reader #(
  parameter int width   = 16,
  parameter int depth   = 4,
  parameter int depthsz = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [width-1:0]   hs_data,
  input  logic               hs_ready,
  output logic               hs_ack,
  output logic [width-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [depthsz:0]   out_count
);

  // Occupancy and pointer constants at the exact widths of the registers.
  localparam logic [depthsz:0]   DEPTH_C = (depthsz + 1)'(depth);
  localparam logic [depthsz:0]   CNT_ONE = (depthsz + 1)'(1);
  localparam logic [depthsz:0]   CNT_ZERO = '0;
  localparam logic [depthsz-1:0] PTR_ONE = depthsz'(1);

  // Two real states. The spare encodings fall back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACK  = 2'b01
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic                 ack_q;
  logic                 ack_d;
  logic [depthsz-1:0]   wr_ptr_q;
  logic [depthsz-1:0]   wr_ptr_d;
  logic [depthsz-1:0]   rd_ptr_q;
  logic [depthsz-1:0]   rd_ptr_d;
  logic [depthsz:0]     count_q;
  logic [depthsz:0]     count_d;
  logic [width-1:0]     mem_q [depth];

  logic                 rdy_s;
  logic                 not_full_s;
  logic                 push_s;
  logic                 pop_s;

  // ---------------------------------------------------------------------------
  // hs_ready sampling
  // ---------------------------------------------------------------------------
`ifdef HS_READER_SYNC_IN_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchroniser on the asynchronous ready level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= hs_ready;
      sync2_q <= sync1_q;
    end
  end

  assign rdy_s = sync2_q;
`else
  assign rdy_s = hs_ready;
`endif

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------

  // The full check uses the registered occupancy only, so a same-cycle pop
  // cannot open a slot. This keeps out_ready off any path to hs_ack.
  assign not_full_s = (count_q < DEPTH_C);

  // Next-state logic. A capture happens only on the IDLE->ACK transition,
  // which gives exactly one capture per rising phase of ready.
  always_comb begin
    state_d = state_q;
    push_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rdy_s && not_full_s) begin
          push_s  = 1'b1;
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!rdy_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // hs_ack is registered and rises on the same edge that writes the word.
  assign ack_d = (state_d == ST_ACK);

  // FSM state and the registered acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  assign hs_ack = ack_q;

  // ---------------------------------------------------------------------------
  // Local queue
  // ---------------------------------------------------------------------------

  // A pop is only meaningful while the queue holds data.
  assign pop_s = (count_q != CNT_ZERO) && out_ready;

  // Pointer and occupancy update. The pointers wrap naturally at depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Queue pointers and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage. It is cleared on reset, so out_data reads zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= hs_data;
    end
  end

  // Stream side: combinational head read. Valid is a decode of registered
  // occupancy.
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != CNT_ZERO);
  assign out_count = count_q;

endmodule

// File: doc/handshake_reader.md
Name: handshake_reader

Overview:
Consumer-side endpoint for the 4-phase ready/ack handshake presented by the cross-domain handshake FIFO's read port. It runs entirely in the slave clock domain.
- Captures each word offered on hs_data/hs_ready and acknowledges it with hs_ack.
- Buffers captured words in a small local queue.
- Re-presents them to slave-domain logic (e.g. the PMK/PTK check pipeline) on a valid/ready stream interface.

Parameters:
width, 16, data word size in bits (must match the FIFO width)
depth, 4, local queue entries (power of two)
depthsz, 2, log2(depth)

Ports:
clk  in  1  slave-domain clock
reset_n  in  1  asynchronous active-low reset
hs_data  in  width  FIFO read data; stable while hs_ready=1
hs_ready  in  1  FIFO has a word offered (level, 4-phase)
hs_ack  out  1  word captured; held until hs_ready falls
out_data  out  width  head of local queue
out_valid  out  1  local queue non-empty
out_ready  in  1  downstream accepts out_data this cycle
out_count  out  depthsz+1  current queue occupancy (0..depth)

Behaviour:
- Reset (async assert, sync deassert handled at system level):
  - hs_ack=0, out_valid=0, out_count=0, out_data=0.
  - Queue pointers = 0; FSM = IDLE.
  - Queue contents are discarded.
  - Both handshake ends must be reset together.
- Signal sampling:
  - hs_ready is sampled as rdy_s.
  - Without SYNC_IN_EN, rdy_s = hs_ready (input already synchronised to clk).
- FSM states:
  - IDLE: hs_ack=0.
    - If rdy_s=1 and out_count<depth: write hs_data at wr_ptr, wr_ptr+1, assert hs_ack on the same edge, go to ACK.
    - If rdy_s=1 and the queue is full: stay in IDLE, no capture, hs_ack stays 0 (backpressure).
  - ACK: hs_ack=1, no captures.
    - When rdy_s=0: drop hs_ack on that edge, go to IDLE.
  - No other states; unreachable encodings return to IDLE.
- Duplicate protection: exactly one capture per rising phase of hs_ready. A word is never captured while hs_ack=1.
- Capture latency: rdy_s seen high at edge N (IDLE, not full) -> hs_ack=1 and the entry is visible after edge N. out_valid=1 in the following cycle if the queue was empty.
- Queue:
  - Register array with wr_ptr/rd_ptr of depthsz bits; both wrap modulo depth.
  - out_data = mem[rd_ptr], combinational read. out_valid = (out_count!=0).
  - Pop when out_valid && out_ready: rd_ptr+1.
  - out_ready while out_valid=0 has no effect.
- Occupancy arithmetic, out_count next value:
  - push only: +1
  - pop only: -1
  - push and pop: unchanged
- Full boundary: push is gated by the registered out_count<depth. It is not bypassed by a same-cycle pop, so no combinational path exists from out_ready to hs_ack. At full with a pop, the capture happens on the next eligible cycle.
- Empty boundary: no bypass path. Data always passes through the queue, so the minimum latency from capture to out_valid is 1 cycle.
- Reset mid-ACK: hs_ack drops immediately. A word in flight is lost from the local queue.

Optional Feature:
- Macro: HS_READER_SYNC_IN_EN.
- Defined: hs_ready passes through a 2-flop synchroniser before use as rdy_s. This adds 2 cycles to both capture latency and hs_ack release latency.
  - hs_data is captured at the edge where rdy_s rises. It is safe because the FIFO holds data stable until it observes hs_ack.
- Undefined: rdy_s = hs_ready directly, with zero added latency.

Test Plan:
1. Single transfer, out_ready=1: hs_ready=1 with hs_data=16'hA5A5 -> next cycle hs_ack=1, out_valid=1, out_data=A5A5. Drop hs_ready -> hs_ack=0 one edge later. out_count returns to 0 after the pop.
2. Burst with out_ready=0: offer 0x0001..0x0005 using the 4-phase handshake -> four acks, out_count=4. Fifth word: hs_ack stays 0. Raise out_ready for 1 cycle -> out_data=0x0001 popped, fifth word acked on the next edge, out_count=4.
3. Sustained push/pop at depth-1 occupancy -> out_count constant, output order 1,2,3,... with no duplicates or drops over 64 words, including pointer wrap.
4. Hold hs_ready=1 for 10 cycles after the ack -> exactly one capture, hs_ack held high for all 10 cycles.
5. Assert reset_n=0 in ACK with out_count=3 -> hs_ack=0 and out_valid=0 asynchronously. After release: FSM in IDLE, a new offer is captured normally.
6. With HS_READER_SYNC_IN_EN defined, repeat test 1 -> hs_ack rises 2 cycles later than without the macro, same data.
